// File: rtl/cook_timer_ctrl_if.sv
// Keypad/door inputs and the digit-counter chain bus of the cook timer controller.
// The controller connects through the slave modport; its environment uses master.
interface cook_timer_ctrl_if;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        start;
    logic        pause;
    logic        cancel;
    logic        door_closed;
    logic [3:0]  cnt_zero;
    logic [3:0]  cnt_load;
    logic [3:0]  cnt_stop;
    logic [15:0] cnt_value;
    logic        heater_on;
    logic        done;
    logic [1:0]  state;

    modport master (
        output key_valid,
        output key_digit,
        output start,
        output pause,
        output cancel,
        output door_closed,
        output cnt_zero,
        input  cnt_load,
        input  cnt_stop,
        input  cnt_value,
        input  heater_on,
        input  done,
        input  state
    );

    modport slave (
        input  key_valid,
        input  key_digit,
        input  start,
        input  pause,
        input  cancel,
        input  door_closed,
        input  cnt_zero,
        output cnt_load,
        output cnt_stop,
        output cnt_value,
        output heater_on,
        output done,
        output state
    );
endinterface

// File: rtl/cook_timer_ctrl.sv
// Cook timer sequencer: keypad entry, MM:SS digit loading, 1 s down-pacing with
// borrow/59-wrap, pause/door/cancel handling and completion flag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | collecting keys into kbuf, digits held
// LOAD    | one cycle: parallel-load kbuf (sec tens clamped) into digits
// RUN     | heater on, prescaler running, digits paced down each tick
// PAUSED  | heater off, digits and prescaler frozen
// DONE    | count reached 00:00, done flag high
module cook_timer_ctrl #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic              clk,
    input  logic              clear,
    cook_timer_ctrl_if.slave  bus
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [15:0]   kbuf_q;
    logic [15:0]   kbuf_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          heater_q;
    logic          done_q;

    logic          tick;
    logic          key_ok;
    logic          all_zero;
    logic [3:0]    sec_tens_clamped;
    logic [15:0]   load_value;
    logic [3:0]    cnt_load_c;
    logic [3:0]    cnt_stop_c;
    logic [15:0]   cnt_value_c;
    logic [1:0]    state_code;

    assign tick             = (presc_q == TICK_LAST);
    assign key_ok           = bus.key_valid && (bus.key_digit <= 4'd9);
    assign all_zero         = (bus.cnt_zero == 4'b1111);
    assign sec_tens_clamped = (kbuf_q[7:4] > 4'd5) ? 4'd5 : kbuf_q[7:4];
    assign load_value       = {kbuf_q[15:8], sec_tens_clamped, kbuf_q[3:0]};

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            kbuf_q   <= '0;
            presc_q  <= '0;
            heater_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kbuf_q   <= kbuf_d;
            presc_q  <= presc_d;
            heater_q <= (state_d == ST_RUN);
            done_q   <= (state_d == ST_DONE);
        end
    end

    always_comb begin
        state_d     = state_q;
        kbuf_d      = kbuf_q;
        presc_d     = presc_q;
        cnt_load_c  = 4'b0000;
        cnt_stop_c  = 4'b1111;
        cnt_value_c = 16'h0000;

        if (bus.cancel) begin
            // Cancel wins everywhere: drop the entry and load zeros into every digit.
            state_d    = ST_IDLE;
            kbuf_d     = '0;
            cnt_load_c = 4'b1111;
            cnt_stop_c = 4'b0000;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start && bus.door_closed && (kbuf_q != 16'h0000)) begin
                        state_d = ST_LOAD;
                    end else if (key_ok) begin
                        kbuf_d = {kbuf_q[11:0], bus.key_digit};
                    end
                end

                ST_LOAD: begin
                    cnt_load_c  = 4'b1111;
                    cnt_stop_c  = 4'b0000;
                    cnt_value_c = load_value;
                    presc_d     = '0;
                    state_d     = ST_RUN;
                end

                ST_RUN: begin
                    if (all_zero) begin
                        state_d = ST_DONE;
                    end else if (bus.pause || !bus.door_closed) begin
                        state_d = ST_PAUSED;
                    end else begin
                        presc_d = tick ? '0 : presc_q + PW'(1);
                        if (tick) begin
                            cnt_stop_c[0] = 1'b0;
                            if (bus.cnt_zero[0]) begin
                                cnt_stop_c[1] = 1'b0;
                                // Seconds tens borrows from 0 back to 5, not 9.
                                if (bus.cnt_zero[1]) begin
                                    cnt_load_c[1]     = 1'b1;
                                    cnt_value_c[7:4]  = 4'd5;
                                end
                            end
                            if (&bus.cnt_zero[1:0]) cnt_stop_c[2] = 1'b0;
                            if (&bus.cnt_zero[2:0]) cnt_stop_c[3] = 1'b0;
                        end
                    end
                end

                ST_PAUSED: begin
                    if (bus.door_closed && !bus.pause && bus.start) begin
                        state_d = ST_RUN;
                    end
                end

                ST_DONE: begin
                    if (!bus.door_closed) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        unique case (state_q)
            ST_IDLE:   state_code = 2'd0;
            ST_LOAD:   state_code = 2'd1;
            ST_RUN:    state_code = 2'd1;
            ST_PAUSED: state_code = 2'd2;
            ST_DONE:   state_code = 2'd3;
            default:   state_code = 2'd0;
        endcase
    end

    assign bus.cnt_load  = cnt_load_c;
    assign bus.cnt_stop  = cnt_stop_c;
    assign bus.cnt_value = cnt_value_c;
    assign bus.heater_on = heater_q;
    assign bus.done      = done_q;
    assign bus.state     = state_code;

endmodule

// File: doc/cook_timer_ctrl.md
# cook_timer_ctrl

Sequencing controller for the microwave cook timer. It collects the keypad time entry and loads it into the four external `counter_mod10` BCD digits (MM:SS). It then paces those digits down once per second with correct borrow and 59→00 seconds wrap, handles pause, door-open and cancel, and flags completion. It sits between the keypad/door inputs and the digit counter chain, and drives the heater enable.

## Interface
- `TICKS_PER_SEC`, default 100: clk cycles per one-second tick, ≥2. The prescaler width is clog2(`TICKS_PER_SEC`).

- `clk`  in  1  system clock; all state changes on rising edge
- `clear`  in  1  synchronous, active-high reset. It is also routed to the digit counters' `clear`.
- `key_valid`  in  1  one-cycle strobe: `key_digit` is valid
- `key_digit`  in  4  BCD digit from the keypad; values >9 ignored
- `start`  in  1  start/resume request (level, sampled each cycle)
- `pause`  in  1  pause request
- `cancel`  in  1  abort/clear request
- `door_closed`  in  1  1 = door closed
- `cnt_zero`  in  4  `zero` flags from the digits: [0] sec units, [1] sec tens, [2] min units, [3] min tens
- `cnt_load`  out  4  per-digit `load`
- `cnt_stop`  out  4  per-digit `stop`; 1 = hold
- `cnt_value`  out  16  per-digit load value; [3:0] → digit0 … [15:12] → digit3
- `heater_on`  out  1  magnetron enable; registered, high only in RUN
- `done`  out  1  cook cycle complete; registered, high only in DONE
- `state`  out  2  IDLE=0, RUN=1, PAUSED=2, DONE=3; the LOAD phase reports 1

## Operation
- Internal state is IDLE, LOAD, RUN, PAUSED, DONE. Digit i's hold is released when `cnt_stop[i]`=0. Any digit with `cnt_load[i]`=1 also has `cnt_stop[i]`=0, because the counter gates load with stop.
- Default outputs every cycle: `cnt_stop`=1111, `cnt_load`=0000, `cnt_value`=0.
- **Keypad buffer:** 16-bit register `kbuf`.
  - In IDLE, a valid key (`key_valid`=1, digit ≤9) shifts in: `kbuf` ← {`kbuf`[11:0], `key_digit`}.
  - Keys are ignored in all other states.
- **Event priority** (highest first): `cancel`, door open (`door_closed`=0), `pause`, `start`.
- **IDLE**
  - `start` & `door_closed` & `kbuf`≠0 → LOAD.
  - `start` with `kbuf`=0 or the door open is ignored.
- **LOAD** (1 cycle)
  - Drives `cnt_load`=1111, `cnt_stop`=0000.
  - `cnt_value` = `kbuf`, except nibble [7:4] is clamped to 5 when it is >5.
  - Prescaler ← 0.
  - Next state: RUN.
- **RUN**
  - Prescaler increments every cycle. tick = (prescaler = `TICKS_PER_SEC`−1); the prescaler wraps to 0 on tick.
  - On a tick cycle with `cnt_zero`≠1111, the digit commands are:
    - d0: `cnt_stop`[0]=0 (decrement; 0→9 wraps naturally).
    - d1: enabled iff `cnt_zero`[0]. If `cnt_zero`[1] is also set, it loads 5 (`cnt_load`[1]=1, value 5) instead of decrementing.
    - d2: enabled iff `cnt_zero`[1:0]=11.
    - d3: enabled iff `cnt_zero`[2:0]=111.
  - `cnt_zero`=1111 (checked every RUN cycle, tick or not) → DONE. No digit is commanded in that cycle, so the digits never underflow.
  - `pause` or door open → PAUSED. The prescaler holds its value.
  - `cancel` → IDLE.
- **PAUSED**
  - Digits are held and the prescaler is frozen.
  - `start` & `door_closed` → RUN; the prescaler resumes from its held value, not reset.
  - `cancel` → IDLE.
- **DONE**
  - `done`=1; digits held at 00:00.
  - `cancel` or door open → IDLE.
- **Any transition to IDLE** via `cancel`:
  - `kbuf` ← 0.
  - In that same cycle, drive `cnt_load`=1111, `cnt_stop`=0000, `cnt_value`=0, which clears the digits.
  - A `cancel` while already in IDLE only clears `kbuf` and the digits.

## Timing
- **Reset:** after a cycle with `clear`=1, the block is in IDLE with `kbuf`=0, prescaler=0, `heater_on`=0, `done`=0, `cnt_stop`=1111, `cnt_load`=0000, `cnt_value`=0. This holds from any state, including mid-RUN.
- **Digit commands** (`cnt_*`) are combinational from registered state, prescaler, `kbuf` and `cnt_zero`. They act at the same edge on which the state sees them.
- **Start latency:**
  - Edge 1 (`start` sampled) → LOAD.
  - Edge 2 loads the digits and enters RUN.
  - `heater_on` rises after edge 2.
- **Tick spacing:** the first decrement lands on the `TICKS_PER_SEC`-th RUN cycle; later decrements follow every `TICKS_PER_SEC` cycles, with PAUSED cycles excluded.
- **End of count:** the last decrement edge makes `cnt_zero`=1111. The next edge enters DONE: `heater_on` falls and `done` rises after that edge.
- **Simultaneous events:** `cancel`+`start` → IDLE. Door open + `start` in PAUSED → stays PAUSED. `key_valid` coinciding with an IDLE→LOAD `start` edge is ignored.

## Test plan
- `TICKS_PER_SEC`=4; keys 0,0,0,3; `start` → LOAD drives `cnt_value`=0x0003; digits count 3,2,1,0 at 4-cycle spacing; `done`=1 one cycle after reaching 0; `heater_on` high for exactly 13 cycles.
- Load 01:00, run one tick → digits read 00:59 (d1 reloaded to 5, d2 decremented); the next tick → 00:58.
- Keys 9,9 (sec tens 9) → LOAD clamps to 0x0059; key 0xC is ignored, `kbuf` unchanged.
- Load 00:10, pulse `pause` after 2 RUN cycles, hold 20 cycles, then `start` → the first decrement occurs 2 RUN cycles after resume; digits frozen while PAUSED; `heater_on`=0 while PAUSED.
- Drop `door_closed` mid-RUN → PAUSED; `start` with the door open → stays PAUSED; close the door and `start` → RUN.
- `cancel` asserted with `start` mid-RUN → IDLE, `kbuf`=0, `cnt_load`=1111 with value 0 that cycle. Then `clear` asserted in DONE → all outputs take their reset values next cycle.
